// File: rtl/mult_seq_mnbit_if.sv
// -----------------------------------------------------------------------------
// mult_seq_mnbit_if
// Request/response bundle for the sequential M x N multiplier.
//   start, a, b       : request (driven by the master)
//   ready, busy, done : status (driven by the slave), exactly one high per cycle
//   prod              : product of the last completed multiply (M+N bits)
//   signed_mode       : only present when MULT_SEQ_SIGNED_EN is defined
// Modports: master (requester side), slave (multiplier side).
// -----------------------------------------------------------------------------
interface mult_seq_mnbit_if #(
  parameter int M = 4,
  parameter int N = 4
);
  logic           start;
  logic [M-1:0]   a;
  logic [N-1:0]   b;
  logic           ready;
  logic           busy;
  logic           done;
  logic [M+N-1:0] prod;
`ifdef MULT_SEQ_SIGNED_EN
  logic           signed_mode;

  modport master (output start, a, b, signed_mode, input ready, busy, done, prod);
  modport slave  (input start, a, b, signed_mode, output ready, busy, done, prod);
`else
  modport master (output start, a, b, input ready, busy, done, prod);
  modport slave  (input start, a, b, output ready, busy, done, prod);
`endif
endinterface

// File: rtl/mult_seq_mnbit.sv
// -----------------------------------------------------------------------------
// mult_seq_mnbit
// Sequential shift-and-add multiplier: one multiplier bit per clock, LSB first.
// Fixed latency: start accepted at edge t -> done high in the cycle after edge
// t+N, ready high again one cycle later.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous, active-high reset (priority over start)
//   bus  : mult_seq_mnbit_if.slave (start, a, b, ready, busy, done, prod)
// Optional build macro MULT_SEQ_SIGNED_EN adds bus.signed_mode, latched with
// the operands; when set, a and b are two's complement (sign-extended adds,
// last partial product subtracted). Without the macro the block is unsigned.
// -----------------------------------------------------------------------------
module mult_seq_mnbit #(
  parameter int M = 4,
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst,
  mult_seq_mnbit_if.slave bus
);
  localparam int W  = M + N;
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [M-1:0]   r_a;
  logic [N-1:0]   r_b;       // shifted right each RUN cycle, bit 0 is current
  logic [W:0]     r_acc;     // M+N+1 bits: partial product lives in [W:N]
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_prod;
`ifdef MULT_SEQ_SIGNED_EN
  logic           r_sm;
`endif

  logic           w_ready;
  logic           w_busy;
  logic           w_done;
  logic           w_accept;
  logic           w_last;
  logic [M:0]     w_a_ext;
  logic           w_sub;
  logic [M:0]     w_sum;
  logic           w_fill;
  logic [W:0]     w_acc_next;

  assign w_last = (r_cnt == CW'(N - 1));

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  // Top field is one bit wider than a so that the add (or the final signed
  // subtract) never overflows; its MSB becomes the shift-in bit.
  always_comb begin
`ifdef MULT_SEQ_SIGNED_EN
    w_a_ext = {r_sm & r_a[M-1], r_a};
    w_sub   = r_sm & w_last;
`else
    w_a_ext = {1'b0, r_a};
    w_sub   = 1'b0;
`endif
    w_sum = r_acc[W:N];
    if (r_b[0]) begin
      if (w_sub) w_sum = r_acc[W:N] - w_a_ext;
      else       w_sum = r_acc[W:N] + w_a_ext;
    end
`ifdef MULT_SEQ_SIGNED_EN
    w_fill = r_sm & w_sum[M];   // arithmetic shift in signed mode
`else
    w_fill = 1'b0;
`endif
    w_acc_next = {w_fill, w_sum, r_acc[N-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_prod <= '0;
`ifdef MULT_SEQ_SIGNED_EN
      r_sm   <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_a   <= bus.a;
        r_b   <= bus.b;
        r_acc <= '0;
        r_cnt <= '0;
`ifdef MULT_SEQ_SIGNED_EN
        r_sm  <= bus.signed_mode;
`endif
      end else if (r_state == S_RUN) begin
        r_acc <= w_acc_next;
        r_b   <= r_b >> 1;
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == S_DONE) r_prod <= r_acc[W-1:0];
    end
  end

  assign bus.ready = w_ready;
  assign bus.busy  = w_busy;
  assign bus.done  = w_done;
  // During DONE the finished accumulator is presented directly so prod is
  // valid alongside the done pulse; afterwards the held copy is shown.
  assign bus.prod  = (r_state == S_DONE) ? r_acc[W-1:0] : r_prod;
endmodule
